haraka_perm_ctrl: RTL
=====================

// Module: haraka_perm_ctrl
// PURPOSE
//  Iterative sequencer for the Haraka-512 permutation datapath: state regs, AES round units, MIX, feed-forward.
//  Each AES round unit is SubBytes, ShiftRow, MixColumns and AddRoundKey.
//  Accepts a job over a valid/ready handshake and issues one datapath command per cycle:
//  load, AES step, MIX, optional feed-forward.
//  Tracks round/step and round-constant index, then holds the result valid until consumed.
//  Sits between the Haraka-S sponge/absorb logic and the shared 512-bit round datapath.
// PARAMETERS
//  ROUNDS        5   Haraka rounds per permutation (>=1)
//  AES_PER_ROUND 2   AES steps per round before each MIX (>=1)
//  RC_W          6   width of dp_rc_base; must be >= clog2(4*ROUNDS*AES_PER_ROUND)
// PORTS
//  clk           in   1     rising-edge clock
//  rst           in   1     asynchronous, active-high reset
//  in_valid      in   1     job request; sponge has loaded dp input bus
//  in_ready      out  1     controller idle, job accepted when in_valid&in_ready
//  in_ff_en      in   1     job attribute, sampled on accept: 1=hash mode (feed-forward), 0=sponge permutation
//  out_valid     out  1     datapath state holds finished result
//  out_ready     in   1     consumer takes result
//  dp_load       out  1     datapath: load input bus into state regs
//  dp_aes_en     out  1     datapath: apply one AES round to all 4 lanes
//  dp_rc_base    out  RC_W  datapath: constant index base; lane i uses RC[dp_rc_base+i]
//  dp_mix_en     out  1     datapath: apply MIX512 lane permutation
//  dp_ff_en      out  1     datapath: XOR saved input into state (feed-forward)
//  busy          out  1     job in flight (not IDLE)
//  perm_count    out  16    completed jobs, saturating
// BEHAVIOUR
//  FSM states, in order of a job:
//   IDLE (reset state)
//   AES (step counter s, round counter r)
//   MIX
//   FF
//   DONE
//  Reset (async, any state incl. mid-job):
//   - state=IDLE, r=0, s=0, ff flag=0, perm_count=0
//   - dp_* all 0, out_valid=0, busy=0, in_ready=1
//   - no partial result is ever presented
//  in_ready = (state==IDLE), combinational.
//  dp_load = in_valid & in_ready (same cycle as accept).
//  All other dp_*, out_valid and busy are decoded from registered state only; no input->output paths.
//  Accept (cycle 0): latch in_ff_en; r<=0; s<=0; go to AES.
//  AES:
//   - dp_aes_en=1, dp_rc_base = 4*(AES_PER_ROUND*r+s)
//   - if s==AES_PER_ROUND-1: s<=0, go to MIX; else s<=s+1
//  MIX:
//   - dp_mix_en=1
//   - if r==ROUNDS-1: go to FF if ff flag, else to DONE
//   - otherwise r<=r+1, go to AES
//  FF: dp_ff_en=1 for one cycle, then DONE.
//  DONE: out_valid=1, held stable until out_ready.
//  On out_valid&out_ready:
//   - go to IDLE
//   - perm_count<=perm_count+1, holding at 16'hFFFF
//  Latency: first out_valid cycle = 1 + ROUNDS*(AES_PER_ROUND+1) + ff.
//   Defaults: 16 (sponge), 17 (hash). No stall occurs between accept and DONE.
//  Throughput: in_ready is low in DONE, so jobs never overlap.
//   With out_ready tied high, a new accept is possible every 17 (18 with FF) cycles.
//  in_valid asserted while busy: ignored, no effect on the running job.
//   in_ff_en changes mid-job: ignored.
//  out_ready high outside DONE: ignored.
//  Exactly one dp_* strobe is high in any cycle; none in IDLE (except dp_load) or DONE.
//  Within a job dp_rc_base runs 0,4,...,4*(ROUNDS*AES_PER_ROUND-1), each value once, monotonic (default max 36).
// TESTING
//  1 Reset mid-job:
//    - assert rst during AES r=2 -> all outputs 0 immediately, in_ready=1, perm_count unchanged at 0 after release
//    - next job runs from rc_base 0
//  2 Sponge job, in_ff_en=0, out_ready=1:
//    - dp_load at c0
//    - AES at c1,c2,c4,c5,..., MIX at c3,c6,...,c15
//    - out_valid at c16
//    - rc_base sequence 0,4,8,...,36
//  3 Hash job, in_ff_en=1: dp_ff_en only at c16, out_valid at c17.
//  4 Backpressure: out_ready=0 for 10 cycles in DONE.
//    - out_valid stays 1, in_ready stays 0
//    - in_valid pulses ignored
//    - perm_count increments once on release
//  5 Back-to-back: in_valid and out_ready tied 1.
//    - accepts at c0,c17,c34
//    - perm_count=3 after third handshake
//    - never two dp strobes in a cycle
//  6 Saturation: force perm_count to 16'hFFFE, run 2 jobs -> perm_count=16'hFFFF, stays there.

Source files
------------

// File: rtl/haraka_perm_ctrl.sv
// ============================================================================
//  Module   : haraka_perm_ctrl
//  Purpose  : Iterative sequencer for the Haraka-512 round datapath
//             (load, AES steps, MIX, optional feed-forward, hold result).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module haraka_perm_ctrl #(
    parameter int ROUNDS        = 5,
    parameter int AES_PER_ROUND = 2,
    parameter int RC_W          = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_ff_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            dp_load,
    output logic            dp_aes_en,
    output logic [RC_W-1:0] dp_rc_base,
    output logic            dp_mix_en,
    output logic            dp_ff_en,
    output logic            busy,
    output logic [15:0]     perm_count
);

    localparam int R_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int S_W = (AES_PER_ROUND > 1) ? $clog2(AES_PER_ROUND) : 1;
    localparam logic [R_W-1:0] R_LAST = R_W'(ROUNDS - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(AES_PER_ROUND - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AES  = 3'd1,
        MIX  = 3'd2,
        FF   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [R_W-1:0]  r_q, r_d;
    logic [S_W-1:0]  s_q, s_d;
    logic            ff_q, ff_d;
    logic [15:0]     cnt_q, cnt_d;

    logic            aes_q, aes_d;
    logic            mix_q, mix_d;
    logic            ffen_q, ffen_d;
    logic            ov_q, ov_d;
    logic            busy_q, busy_d;
    logic [RC_W-1:0] rc_q, rc_d;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        s_d     = s_q;
        ff_d    = ff_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = AES;
                    r_d     = '0;
                    s_d     = '0;
                    ff_d    = in_ff_en;
                end
            end
            AES: begin
                if (s_q == S_LAST) begin
                    s_d     = '0;
                    state_d = MIX;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            MIX: begin
                if (r_q == R_LAST) begin
                    state_d = ff_q ? FF : DONE;
                end else begin
                    r_d     = r_q + 1'b1;
                    state_d = AES;
                end
            end
            FF: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from the next state so they leave flops
        // aligned with the state they describe.
        aes_d  = (state_d == AES);
        mix_d  = (state_d == MIX);
        ffen_d = (state_d == FF);
        ov_d   = (state_d == DONE);
        busy_d = (state_d != IDLE);
        rc_d   = '0;
        if (state_d == AES) begin
            rc_d = RC_W'(4 * (AES_PER_ROUND * int'(r_d) + int'(s_d)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            s_q     <= '0;
            ff_q    <= 1'b0;
            cnt_q   <= '0;
            aes_q   <= 1'b0;
            mix_q   <= 1'b0;
            ffen_q  <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            ff_q    <= ff_d;
            cnt_q   <= cnt_d;
            aes_q   <= aes_d;
            mix_q   <= mix_d;
            ffen_q  <= ffen_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            rc_q    <= rc_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign dp_load    = in_valid & in_ready;
    assign dp_aes_en  = aes_q;
    assign dp_mix_en  = mix_q;
    assign dp_ff_en   = ffen_q;
    assign dp_rc_base = rc_q;
    assign out_valid  = ov_q;
    assign busy       = busy_q;
    assign perm_count = cnt_q;

endmodule

`default_nettype wire
